// File: rtl/sample_scheduler.sv
// sample_scheduler
//   Walks a regular subsample grid across a triangle's bounding box in raster
//   order, one sample per cycle, holding the triangle and colour stable.
//   A new triangle is accepted only once the current one is exhausted.
//   halt_RnnH freezes the walk; a sample is consumed on cycles where
//   validSamp_R16H=1 and halt_RnnH=0. All outputs are registered.
//
// Ports
//   clk              clock
//   rst              synchronous reset, active low
//   tri_R14S         incoming triangle vertices [VERTS][AXIS]
//   color_R14U       incoming colour [COLORS]
//   bbox_R14S        bounding box, [0]=lower-left, [1]=upper-right, [.][0]=x, [.][1]=y
//   subSample_R14U   samples-per-axis shift s, step = 1 << (RADIX - s)
//   validTri_R14H    incoming triangle valid
//   readyTri_R14H    scheduler can accept a triangle
//   halt_RnnH        downstream stall
//   tri_R16S         held triangle
//   color_R16U       held colour
//   sample_R16S      current sample (x,y)
//   validSamp_R16H   sample_R16S valid
//   sampCount_R16U   (SAMPLE_SCHED_PERF_EN) saturating count of consumed samples
//   stallCount_R16U  (SAMPLE_SCHED_PERF_EN) saturating count of stalled sample cycles
//
// Build option: define SAMPLE_SCHED_PERF_EN to add the two performance counters.
//
// States
//   state    | meaning
//   ST_WAIT  | idle, ready for a triangle, no sample presented
//   ST_TEST  | presenting grid samples of the held triangle

module sample_scheduler #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R14U [COLORS],
    input  logic signed [SIGFIG-1:0] bbox_R14S [2][2],
    input  logic        [1:0]        subSample_R14U,
    input  logic                     validTri_R14H,
    output logic                     readyTri_R14H,
    input  logic                     halt_RnnH,
    output logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R16U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R16S [2],
    output logic                     validSamp_R16H
`ifdef SAMPLE_SCHED_PERF_EN
    ,
    output logic        [31:0]       sampCount_R16U,
    output logic        [31:0]       stallCount_R16U
`endif
);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    localparam logic [SIGFIG-1:0] STEP_ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

    state_t state_q;
    state_t state_nxt;

    logic signed [SIGFIG-1:0] ll_x;
    logic signed [SIGFIG-1:0] ur_x;
    logic signed [SIGFIG-1:0] ur_y;
    logic        [SIGFIG-1:0] step;

    // One extra bit so that stepping past a bound near +max never wraps.
    logic signed [SIGFIG:0] next_x;
    logic signed [SIGFIG:0] next_y;
    logic signed [SIGFIG:0] ur_x_ext;
    logic signed [SIGFIG:0] ur_y_ext;
    logic                   x_fits;
    logic                   y_fits;
    logic                   bbox_ok;

    logic accept;
    logic advance;
    logic last;

    always_comb begin
        next_x   = $signed({sample_R16S[0][SIGFIG-1], sample_R16S[0]}) + $signed({1'b0, step});
        next_y   = $signed({sample_R16S[1][SIGFIG-1], sample_R16S[1]}) + $signed({1'b0, step});
        ur_x_ext = $signed({ur_x[SIGFIG-1], ur_x});
        ur_y_ext = $signed({ur_y[SIGFIG-1], ur_y});
        x_fits   = (next_x <= ur_x_ext);
        y_fits   = (next_y <= ur_y_ext);
        bbox_ok  = (bbox_R14S[0][0] <= bbox_R14S[1][0]) &&
                   (bbox_R14S[0][1] <= bbox_R14S[1][1]);
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        advance   = 1'b0;
        last      = 1'b0;
        case (state_q)
            ST_WAIT: begin
                // readyTri_R14H gates acceptance so nothing is taken on the
                // cycle right after reset, when ready is still low.
                if (readyTri_R14H && validTri_R14H) begin
                    accept = 1'b1;
                    if (bbox_ok) begin
                        state_nxt = ST_TEST;
                    end
                end
            end
            ST_TEST: begin
                if (!halt_RnnH) begin
                    advance = 1'b1;
                    if (!x_fits && !y_fits) begin
                        last      = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_WAIT;
            readyTri_R14H  <= 1'b0;
            validSamp_R16H <= 1'b0;
            ll_x           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            step           <= '0;
            sample_R16S[0] <= '0;
            sample_R16S[1] <= '0;
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    tri_R16S[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                color_R16U[c] <= '0;
            end
        end else begin
            state_q        <= state_nxt;
            readyTri_R14H  <= (state_nxt == ST_WAIT);
            validSamp_R16H <= (state_nxt == ST_TEST);
            if (accept) begin
                tri_R16S       <= tri_R14S;
                color_R16U     <= color_R14U;
                ll_x           <= bbox_R14S[0][0];
                ur_x           <= bbox_R14S[1][0];
                ur_y           <= bbox_R14S[1][1];
                step           <= STEP_ONE << (RADIX - int'(subSample_R14U));
                sample_R16S[0] <= bbox_R14S[0][0];
                sample_R16S[1] <= bbox_R14S[0][1];
            end else if (advance && !last) begin
                // The final sample is left in place; only validSamp_R16H drops.
                if (x_fits) begin
                    sample_R16S[0] <= next_x[SIGFIG-1:0];
                end else begin
                    sample_R16S[0] <= ll_x;
                    sample_R16S[1] <= next_y[SIGFIG-1:0];
                end
            end
        end
    end

`ifdef SAMPLE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            sampCount_R16U  <= '0;
            stallCount_R16U <= '0;
        end else begin
            if (validSamp_R16H && !halt_RnnH && (sampCount_R16U != '1)) begin
                sampCount_R16U <= sampCount_R16U + 32'd1;
            end
            if (validSamp_R16H && halt_RnnH && (stallCount_R16U != '1)) begin
                stallCount_R16U <= stallCount_R16U + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler. A queue-based model predicts the sample stream
// of every accepted triangle from nested grid loops; a negedge process
// compares every output each cycle. Directed scenarios also pin the model
// with hand-computed sample lists.
module tb_sample_scheduler;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam longint XMAX = 64'sd8388607;

    logic                     clk;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U [COLORS];
    logic signed [SIGFIG-1:0] bbox_R14S [2][2];
    logic        [1:0]        subSample_R14U;
    logic                     validTri_R14H;
    logic                     readyTri_R14H;
    logic                     halt_RnnH;
    logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R16U [COLORS];
    logic signed [SIGFIG-1:0] sample_R16S [2];
    logic                     validSamp_R16H;
`ifdef SAMPLE_SCHED_PERF_EN
    logic        [31:0]       sampCount_R16U;
    logic        [31:0]       stallCount_R16U;
`endif

    int checks = 0;
    int errors = 0;

    sample_scheduler #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tri_R14S       (tri_R14S),
        .color_R14U     (color_R14U),
        .bbox_R14S      (bbox_R14S),
        .subSample_R14U (subSample_R14U),
        .validTri_R14H  (validTri_R14H),
        .readyTri_R14H  (readyTri_R14H),
        .halt_RnnH      (halt_RnnH),
        .tri_R16S       (tri_R16S),
        .color_R16U     (color_R16U),
        .sample_R16S    (sample_R16S),
        .validSamp_R16H (validSamp_R16H)
`ifdef SAMPLE_SCHED_PERF_EN
        ,
        .sampCount_R16U (sampCount_R16U),
        .stallCount_R16U(stallCount_R16U)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    longint px[$];
    longint py[$];
    bit     m_ready = 1'b0;
    bit     m_zero  = 1'b1;
    logic signed [SIGFIG-1:0] m_tri [VERTS][AXIS] = '{default: '0};
    logic        [SIGFIG-1:0] m_color [COLORS]    = '{default: '0};
    longint m_samp  = 0;
    longint m_stall = 0;

    // consumed samples as observed at the DUT outputs
    longint seen_x[$];
    longint seen_y[$];
    int     hold_cnt = 0;

    task automatic build_list(input longint llx, input longint lly, input longint urx,
                              input longint ury, input longint stp);
        for (longint y = lly; y <= ury; y += stp) begin
            for (longint x = llx; x <= urx; x += stp) begin
                px.push_back(x);
                py.push_back(y);
            end
        end
    endtask

    always @(negedge clk) begin
        bit m_valid;
        m_valid = (px.size() != 0);
        chk("ready", readyTri_R14H, m_ready);
        chk("valid", validSamp_R16H, m_valid);
        if (m_valid) begin
            chk("sample_x", sample_R16S[0], px[0]);
            chk("sample_y", sample_R16S[1], py[0]);
        end
        if (m_zero) begin
            chk("reset_sample_x", sample_R16S[0], 0);
            chk("reset_sample_y", sample_R16S[1], 0);
        end
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                chk("tri", tri_R16S[v][a], m_tri[v][a]);
        for (int c = 0; c < COLORS; c++)
            chk("color", color_R16U[c], m_color[c]);
`ifdef SAMPLE_SCHED_PERF_EN
        chk("samp_count", sampCount_R16U, m_samp);
        chk("stall_count", stallCount_R16U, m_stall);
`endif
        if (validSamp_R16H === 1'b1 && halt_RnnH === 1'b0) begin
            seen_x.push_back(longint'(sample_R16S[0]));
            seen_y.push_back(longint'(sample_R16S[1]));
        end
        if (validSamp_R16H === 1'b1 && sample_R16S[0] == 24'sd1024 && sample_R16S[1] == 24'sd0)
            hold_cnt++;

        // predict the state after the coming rising edge
        if (rst === 1'b0) begin
            px.delete();
            py.delete();
            m_ready = 1'b0;
            m_zero  = 1'b1;
            m_tri   = '{default: '0};
            m_color = '{default: '0};
            m_samp  = 0;
            m_stall = 0;
        end else begin
            m_zero = 1'b0;
            if (m_valid) begin
                if (halt_RnnH) begin
                    m_stall++;
                end else begin
                    m_samp++;
                    void'(px.pop_front());
                    void'(py.pop_front());
                    if (px.size() == 0) m_ready = 1'b1;
                end
            end else if (m_ready && validTri_R14H) begin
                m_tri   = tri_R14S;
                m_color = color_R14U;
                build_list(bbox_R14S[0][0], bbox_R14S[0][1], bbox_R14S[1][0], bbox_R14S[1][1],
                           longint'(1) << (RADIX - int'(subSample_R14U)));
                m_ready = (px.size() == 0);
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    longint ex[$];
    longint ey[$];

    task automatic send_tri(input int seed, input longint llx, input longint lly,
                            input longint urx, input longint ury, input int s);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R14S[v][a] = SIGFIG'(seed * 1000 - v * 37 - a * 5 - 400);
        for (int c = 0; c < COLORS; c++)
            color_R14U[c] = SIGFIG'(seed * 4099 + c * 13 + 1);
        bbox_R14S[0][0] = SIGFIG'(llx);
        bbox_R14S[0][1] = SIGFIG'(lly);
        bbox_R14S[1][0] = SIGFIG'(urx);
        bbox_R14S[1][1] = SIGFIG'(ury);
        subSample_R14U  = 2'(s);
        validTri_R14H   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (readyTri_R14H === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready, expected ready within 200 cycles");
        end
        @(posedge clk);
        #1;
        validTri_R14H = 1'b0;
    endtask

    task automatic wait_idle(input bit random_halt);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (readyTri_R14H === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (random_halt) begin
                @(posedge clk);
                #1;
                halt_RnnH = 1'($urandom_range(0, 1));
            end
        end
        halt_RnnH = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got no ready, expected ready within 400 cycles");
        end
    endtask

    task automatic check_seen(input string name, input int base);
        chk({name, "_count"}, seen_x.size() - base, ex.size());
        for (int i = 0; i < ex.size(); i++) begin
            if (base + i < seen_x.size()) begin
                chk({name, "_x"}, seen_x[base + i], ex[i]);
                chk({name, "_y"}, seen_y[base + i], ey[i]);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int base;
        int hbase;
        rst            = 1'b0;
        validTri_R14H  = 1'b0;
        halt_RnnH      = 1'b0;
        subSample_R14U = 2'd0;
        tri_R14S       = '{default: '0};
        color_R14U     = '{default: '0};
        bbox_R14S      = '{default: '0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", readyTri_R14H, 0);
        chk("reset_valid", validSamp_R16H, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("release_ready_low", readyTri_R14H, 0);
        @(negedge clk);
        chk("release_ready_high", readyTri_R14H, 1);

        // basic grid
        base = seen_x.size();
        send_tri(1, 0, 0, 2048, 1024, 0);
        wait_idle(1'b0);
        ex = '{0, 1024, 2048, 0, 1024, 2048};
        ey = '{0, 0, 0, 1024, 1024, 1024};
        check_seen("grid", base);

        // subsample step
        base = seen_x.size();
        send_tri(2, 0, 0, 512, 0, 2);
        wait_idle(1'b0);
        ex = '{0, 256, 512};
        ey = '{0, 0, 0};
        check_seen("subsample", base);

        // halt while (1024,0) is presented
        base  = seen_x.size();
        hbase = hold_cnt;
        send_tri(3, 0, 0, 2048, 1024, 0);
        @(posedge clk);
        #1 halt_RnnH = 1'b1;
        repeat (3) @(posedge clk);
        #1 halt_RnnH = 1'b0;
        wait_idle(1'b0);
        ex = '{0, 1024, 2048, 0, 1024, 2048};
        ey = '{0, 0, 0, 1024, 1024, 1024};
        check_seen("halt", base);
        chk("halt_hold_cycles", hold_cnt - hbase, 4);

        // degenerate box
        base = seen_x.size();
        send_tri(4, 2048, 0, 1024, 0, 0);
        @(negedge clk);
        chk("degen_ready0", readyTri_R14H, 1);
        @(negedge clk);
        chk("degen_ready1", readyTri_R14H, 1);
        chk("degen_samples", seen_x.size() - base, 0);

        // reset after the second sample
        send_tri(5, 0, 0, 2048, 1024, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", validSamp_R16H, 0);
        chk("midrst_ready", readyTri_R14H, 0);
        chk("midrst_tri", tri_R16S[0][0], 0);
        chk("midrst_color", color_R16U[2], 0);
        chk("midrst_sample", sample_R16S[0], 0);
        @(negedge clk);
        chk("midrst_ready_back", readyTri_R14H, 1);
        base = seen_x.size();
        send_tri(6, 0, 0, 512, 0, 2);
        wait_idle(1'b0);
        ex = '{0, 256, 512};
        ey = '{0, 0, 0};
        check_seen("after_reset", base);

        // negative coordinates, other steps, random stalls (model only)
        send_tri(7, -1024, -1024, 0, 0, 0);
        wait_idle(1'b1);
        send_tri(8, -3000, 5, 100, 700, 1);
        wait_idle(1'b1);
        send_tri(9, 100, 100, 100, 100, 3);
        wait_idle(1'b1);
        send_tri(10, -8388608, -2048, -8388608 + 3000, -1024, 0);
        wait_idle(1'b1);

        // upper x bound at +max: one sample, stepping past must not wrap
        do_reset();
        base = seen_x.size();
        send_tri(11, XMAX - 1023, 0, XMAX, 0, 0);
        halt_RnnH = 1'b1;
        repeat (2) @(posedge clk);
        #1 halt_RnnH = 1'b0;
        wait_idle(1'b0);
        ex = '{8387584};
        ey = '{0};
        check_seen("ovf_one", base);
`ifdef SAMPLE_SCHED_PERF_EN
        chk("ovf_samp_count", sampCount_R16U, 1);
        chk("ovf_stall_count", stallCount_R16U, 2);
`endif
        // ll.x = ur.x-1024 lands exactly on ur.x, so two samples
        base = seen_x.size();
        send_tri(12, XMAX - 1024, 0, XMAX, 0, 0);
        wait_idle(1'b0);
        ex = '{8387583, 8388607};
        ey = '{0, 0};
        check_seen("ovf_two", base);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
